// File: rtl/writeback_arbiter_if.sv
// Writeback port bundle: ALU result, mem result handshake and register-file write port.
// The arbiter takes the slave side; the producer/consumer environment takes master.
interface writeback_arbiter_if;
  logic        alu_valid_i;
  logic [2:0]  alu_addr_i;
  logic [15:0] alu_data_i;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [2:0]  mem_addr_i;
  logic [15:0] mem_data_i;
  logic        write_en_o;
  logic [2:0]  write_addr_o;
  logic [15:0] write_data_o;
  logic [1:0]  fifo_count_o;
  logic        alu_stall_o;
  logic        protocol_err_o;

  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  mem_valid_i, mem_addr_i, mem_data_i,
    output mem_ready_o,
    output write_en_o, write_addr_o, write_data_o,
    output fifo_count_o, alu_stall_o, protocol_err_o
  );

  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output mem_valid_i, mem_addr_i, mem_data_i,
    input  mem_ready_o,
    input  write_en_o, write_addr_o, write_data_o,
    input  fifo_count_o, alu_stall_o, protocol_err_o
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the un-stallable ALU result stream and the handshaked mem result stream onto a
// single register-file write port, buffering up to two mem results in order.
module writeback_arbiter (
  input  logic               clk_i,
  input  logic               rst_i,
  writeback_arbiter_if.slave bus
);

  logic [1:0]       fifo_valid_r, fifo_valid_s;
  logic [1:0][2:0]  fifo_addr_r, fifo_addr_s;
  logic [1:0][15:0] fifo_data_r, fifo_data_s;
  logic [1:0]       fifo_count_r, fifo_count_s;
  logic [1:0]       head_age_r;
  logic             write_en_r, write_en_s;
  logic [2:0]       write_addr_r, write_addr_s;
  logic [15:0]      write_data_r, write_data_s;
  logic             protocol_err_r;
  logic             mem_ready_s, alu_stall_s, mem_accept_s, alu_write_s;
  logic             deq_s, enq_s;

  assign mem_ready_s  = rst_i & (fifo_count_r != 2'd2);
  assign alu_stall_s  = rst_i & (head_age_r == 2'd3);
  assign mem_accept_s = bus.mem_valid_i & mem_ready_s;
  assign alu_write_s  = bus.alu_valid_i & (bus.alu_addr_i != 3'd0);

  // Selection, squash and FIFO next-state; the ALU is younger, so it kills matching mem data.
  always_comb begin
    fifo_addr_s  = fifo_addr_r;
    fifo_data_s  = fifo_data_r;
    fifo_count_s = fifo_count_r;
    write_en_s   = 1'b0;
    write_addr_s = write_addr_r;
    write_data_s = write_data_r;
    deq_s        = 1'b0;
    enq_s        = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_valid_s[i] = fifo_valid_r[i] & ~(alu_write_s & (fifo_addr_r[i] == bus.alu_addr_i));
    end
    if (bus.alu_valid_i) begin
      write_en_s = alu_write_s;
      if (alu_write_s) begin
        write_addr_s = bus.alu_addr_i;
        write_data_s = bus.alu_data_i;
      end else begin
        write_addr_s = write_addr_r;
      end
      enq_s = mem_accept_s & (bus.mem_addr_i != 3'd0)
              & ~(alu_write_s & (bus.mem_addr_i == bus.alu_addr_i));
    end else if (fifo_count_r != 2'd0) begin
      // Head leaves the FIFO even when squashed; only a valid head produces a write.
      deq_s      = 1'b1;
      write_en_s = fifo_valid_r[0];
      if (fifo_valid_r[0]) begin
        write_addr_s = fifo_addr_r[0];
        write_data_s = fifo_data_r[0];
      end else begin
        write_addr_s = write_addr_r;
      end
      fifo_valid_s[0] = fifo_valid_r[1];
      fifo_addr_s[0]  = fifo_addr_r[1];
      fifo_data_s[0]  = fifo_data_r[1];
      fifo_valid_s[1] = 1'b0;
      fifo_count_s    = fifo_count_r - 2'd1;
      enq_s           = mem_accept_s & (bus.mem_addr_i != 3'd0);
    end else if (mem_accept_s && (bus.mem_addr_i != 3'd0)) begin
      write_en_s   = 1'b1;
      write_addr_s = bus.mem_addr_i;
      write_data_s = bus.mem_data_i;
    end else begin
      write_en_s = 1'b0;
    end
    if (enq_s) begin
      if (fifo_count_s == 2'd0) begin
        fifo_valid_s[0] = 1'b1;
        fifo_addr_s[0]  = bus.mem_addr_i;
        fifo_data_s[0]  = bus.mem_data_i;
      end else begin
        fifo_valid_s[1] = 1'b1;
        fifo_addr_s[1]  = bus.mem_addr_i;
        fifo_data_s[1]  = bus.mem_data_i;
      end
      fifo_count_s = fifo_count_s + 2'd1;
    end else begin
      fifo_count_s = fifo_count_s;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fifo_valid_r   <= 2'b00;
      fifo_addr_r    <= '0;
      fifo_data_r    <= '0;
      fifo_count_r   <= 2'd0;
      head_age_r     <= 2'd0;
      write_en_r     <= 1'b0;
      write_addr_r   <= 3'd0;
      write_data_r   <= 16'd0;
      protocol_err_r <= 1'b0;
    end else begin
      fifo_valid_r <= fifo_valid_s;
      fifo_addr_r  <= fifo_addr_s;
      fifo_data_r  <= fifo_data_s;
      fifo_count_r <= fifo_count_s;
      write_en_r   <= write_en_s;
      write_addr_r <= write_addr_s;
      write_data_r <= write_data_s;
      if ((fifo_count_r == 2'd0) || deq_s) begin
        head_age_r <= 2'd0;
      end else if (head_age_r != 2'd3) begin
        head_age_r <= head_age_r + 2'd1;
      end else begin
        head_age_r <= head_age_r;
      end
      if (bus.alu_valid_i && alu_stall_s) begin
        protocol_err_r <= 1'b1;
      end else begin
        protocol_err_r <= protocol_err_r;
      end
    end
  end

  assign bus.mem_ready_o    = mem_ready_s;
  assign bus.alu_stall_o    = alu_stall_s;
  assign bus.write_en_o     = write_en_r;
  assign bus.write_addr_o   = write_addr_r;
  assign bus.write_data_o   = write_data_r;
  assign bus.fifo_count_o   = fifo_count_r;
  assign bus.protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_writeback_arbiter;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  writeback_arbiter_if bus();
  writeback_arbiter dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));

  typedef struct {
    logic        valid;
    logic [2:0]  addr;
    logic [15:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_wen;
  logic [2:0]  m_waddr;
  logic [15:0] m_wdata;
  int          m_wait;
  logic        m_err;
  int          total = 0;
  int          bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a write happens one cycle after selection; ALU > oldest queued > new mem.
  task automatic model_step();
    logic acc;
    logic had_items;
    ent_t h;
    m_wen = 1'b0;
    if (!rst_i) begin
      q.delete();
      m_waddr = 3'd0;
      m_wdata = 16'd0;
      m_wait  = 0;
      m_err   = 1'b0;
    end else begin
      acc = bus.mem_valid_i && (q.size() < 2);
      had_items = (q.size() > 0);
      if (bus.alu_valid_i && m_wait >= 3) m_err = 1'b1;
      if (bus.alu_valid_i) begin
        if (bus.alu_addr_i != 3'd0) begin
          m_wen = 1'b1; m_waddr = bus.alu_addr_i; m_wdata = bus.alu_data_i;
          foreach (q[i]) if (q[i].addr == bus.alu_addr_i) q[i].valid = 1'b0;
        end
        if (acc && bus.mem_addr_i != 3'd0 &&
            !(bus.alu_addr_i != 3'd0 && bus.mem_addr_i == bus.alu_addr_i))
          q.push_back('{1'b1, bus.mem_addr_i, bus.mem_data_i});
        m_wait = had_items ? m_wait + 1 : 0;
      end else if (had_items) begin
        h = q.pop_front();
        if (h.valid) begin
          m_wen = 1'b1; m_waddr = h.addr; m_wdata = h.data;
        end
        if (acc && bus.mem_addr_i != 3'd0) q.push_back('{1'b1, bus.mem_addr_i, bus.mem_data_i});
        m_wait = 0;
      end else begin
        if (acc && bus.mem_addr_i != 3'd0) begin
          m_wen = 1'b1; m_waddr = bus.mem_addr_i; m_wdata = bus.mem_data_i;
        end
        m_wait = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("write_en", {31'd0, bus.write_en_o}, {31'd0, m_wen});
    if (m_wen) begin
      chk("write_addr", {29'd0, bus.write_addr_o}, {29'd0, m_waddr});
      chk("write_data", {16'd0, bus.write_data_o}, {16'd0, m_wdata});
    end
    chk("fifo_count", {30'd0, bus.fifo_count_o}, q.size());
    chk("mem_ready", {31'd0, bus.mem_ready_o}, {31'd0, (rst_i && q.size() < 2)});
    chk("alu_stall", {31'd0, bus.alu_stall_o}, {31'd0, (rst_i && m_wait >= 3)});
    chk("protocol_err", {31'd0, bus.protocol_err_o}, {31'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic drive(logic av, logic [2:0] aa, logic [15:0] ad,
                       logic mv, logic [2:0] ma, logic [15:0] md);
    bus.alu_valid_i = av; bus.alu_addr_i = aa; bus.alu_data_i = ad;
    bus.mem_valid_i = mv; bus.mem_addr_i = ma; bus.mem_data_i = md;
  endtask

  initial begin
    rst_i = 1'b0;
    m_wen = 1'b0; m_waddr = 3'd0; m_wdata = 16'd0; m_wait = 0; m_err = 1'b0;
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.mem_ready_o}, 32'd0);
    chk("rst_waddr", {29'd0, bus.write_addr_o}, 32'd0);
    chk("rst_wdata", {16'd0, bus.write_data_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    chk("ready_after_release", {31'd0, bus.mem_ready_o}, 32'd1);

    // Lone ALU write
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0);
    tick();
    chk("alu_only_en", {31'd0, bus.write_en_o}, 32'd1);
    chk("alu_only_addr", {29'd0, bus.write_addr_o}, 32'd3);
    chk("alu_only_data", {16'd0, bus.write_data_o}, 32'h1234);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    chk("alu_only_idle", {31'd0, bus.write_en_o}, 32'd0);

    // ALU and mem together: mem parked one cycle
    drive(1'b1, 3'd2, 16'h00AA, 1'b1, 3'd5, 16'hBEEF);
    tick();
    chk("both_alu_addr", {29'd0, bus.write_addr_o}, 32'd2);
    chk("both_count1", {30'd0, bus.fifo_count_o}, 32'd1);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    chk("both_mem_en", {31'd0, bus.write_en_o}, 32'd1);
    chk("both_mem_addr", {29'd0, bus.write_addr_o}, 32'd5);
    chk("both_mem_data", {16'd0, bus.write_data_o}, 32'hBEEF);
    chk("both_count0", {30'd0, bus.fifo_count_o}, 32'd0);

    // Register 0 targets are dropped
    drive(1'b1, 3'd0, 16'h1111, 1'b1, 3'd0, 16'h2222);
    tick();
    chk("r0_no_write", {31'd0, bus.write_en_o}, 32'd0);
    chk("r0_ready", {31'd0, bus.mem_ready_o}, 32'd1);
    chk("r0_count", {30'd0, bus.fifo_count_o}, 32'd0);

    // Queued r7 squashed by younger ALU r7
    drive(1'b1, 3'd4, 16'h0044, 1'b1, 3'd7, 16'h5555);
    tick();
    drive(1'b1, 3'd7, 16'h0001, 1'b0, 3'd0, 16'd0);
    tick();
    chk("squash_alu_addr", {29'd0, bus.write_addr_o}, 32'd7);
    chk("squash_alu_data", {16'd0, bus.write_data_o}, 32'h0001);
    chk("squash_count_kept", {30'd0, bus.fifo_count_o}, 32'd1);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    chk("squash_pop_no_write", {31'd0, bus.write_en_o}, 32'd0);
    chk("squash_pop_count", {30'd0, bus.fifo_count_o}, 32'd0);

    // Starvation: ALU every cycle, mem backs up, stall after the head waits 3 cycles
    drive(1'b1, 3'd4, 16'h0404, 1'b1, 3'd6, 16'h0606);
    tick();
    tick();
    chk("starve_full", {30'd0, bus.fifo_count_o}, 32'd2);
    tick();
    chk("starve_not_ready", {31'd0, bus.mem_ready_o}, 32'd0);
    chk("starve_no_stall_yet", {31'd0, bus.alu_stall_o}, 32'd0);
    tick();
    chk("starve_stall", {31'd0, bus.alu_stall_o}, 32'd1);
    drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'h0606);
    tick();
    chk("drain_en", {31'd0, bus.write_en_o}, 32'd1);
    chk("drain_addr", {29'd0, bus.write_addr_o}, 32'd6);
    chk("drain_stall_clear", {31'd0, bus.alu_stall_o}, 32'd0);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    tick();
    tick();
    chk("drain_empty", {30'd0, bus.fifo_count_o}, 32'd0);

    // Mid-operation reset flushes the FIFO
    drive(1'b1, 3'd4, 16'h0404, 1'b1, 3'd6, 16'h0606);
    tick();
    tick();
    chk("prerst_full", {30'd0, bus.fifo_count_o}, 32'd2);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    rst_i = 1'b0;
    tick();
    chk("midrst_count", {30'd0, bus.fifo_count_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    chk("postrst_ready", {31'd0, bus.mem_ready_o}, 32'd1);
    chk("postrst_no_write", {31'd0, bus.write_en_o}, 32'd0);
    tick();
    chk("postrst_no_write2", {31'd0, bus.write_en_o}, 32'd0);

    // ALU issued during stall sets sticky error
    drive(1'b1, 3'd4, 16'h0404, 1'b1, 3'd6, 16'h0606);
    for (int i = 0; i < 5; i++) tick();
    chk("err_set", {31'd0, bus.protocol_err_o}, 32'd1);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    tick();
    tick();
    chk("err_sticky", {31'd0, bus.protocol_err_o}, 32'd1);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    chk("err_cleared", {31'd0, bus.protocol_err_o}, 32'd0);
    tick();

    // Randomized traffic; narrow address range so squashes and r0 drops are frequent
    for (int n = 0; n < 1500; n++) begin
      logic av;
      av = ($urandom_range(0, 99) < 45);
      if (m_wait >= 3 && $urandom_range(0, 39) != 0) av = 1'b0;
      drive(av, 3'($urandom_range(0, 7)), 16'($urandom),
            ($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 16'($urandom));
      rst_i = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
